// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder evaluation per clock, LSB first,
// with a start/busy/done handshake and registered sum, carry-out and signed overflow.
`timescale 1ns/1ps

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             accept;
   logic             last;
   logic             s;
   logic             c;
   logic             cmsb;

   // The single full-adder cell, fed from the LSBs of the operand shift registers.
   always_comb begin
      s    = opa[0] ^ opb[0] ^ carry;
      c    = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
      cmsb = carry;
      last = (state == RUN) && (cnt == CW'(WIDTH - 1));
   end

   // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: all datapath registers are explicitly cleared; none is left to power-up value.
   always_ff @(posedge clk) begin
      if (reset) begin
         opa   <= '0;
         opb   <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         opa   <= a;
         opb   <= sub ? ~b : b;
         carry <= sub | cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         opa   <= opa >> 1;
         opb   <= opb >> 1;
         res   <= {s, res[WIDTH-1:1]};
         carry <= c;
         if (last) begin
            // Counter parks on the final bit; the next accept reloads it.
            sum  <= {s, res[WIDTH-1:1]};
            cout <= c;
            ovf  <= cmsb ^ c;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule
